rv32i_test_sequencer: RTL and testbench

//  Sequences one self-checking run of the RV32I single-cycle core (RV32I_TOP).

---
 rtl/rv32i_seq_pkg.sv | 22 ++
 rtl/rv32i_store_monitor.sv | 23 ++
 rtl/rv32i_test_sequencer.sv | 178 +++++++++++++++++
 tb/tb_rv32i_test_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_seq_pkg.sv
// rtl/rv32i_seq_pkg.sv - shared types and default signature constants for the RV32I test sequencer
package rv32i_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_HOLD,
      ST_RUN,
      ST_PASS,
      ST_FAIL,
      ST_TIMEOUT
   } seq_state_t;

   localparam logic [31:0] DEF_PASS_ADDR  = 32'd100;
   localparam logic [31:0] DEF_PASS_DATA  = 32'd25;
   localparam logic [31:0] DEF_ALLOW_ADDR = 32'd96;

   function automatic logic is_terminal(input seq_state_t s);
      return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
   endfunction

endpackage

// File: rtl/rv32i_store_monitor.sv
// rtl/rv32i_store_monitor.sv - combinational pass/fail classification of one core data-memory store
module rv32i_store_monitor
   import rv32i_seq_pkg::*;
#(
   parameter logic [31:0] PASS_ADDR  = DEF_PASS_ADDR,
   parameter logic [31:0] PASS_DATA  = DEF_PASS_DATA,
   parameter logic [31:0] ALLOW_ADDR = DEF_ALLOW_ADDR
) (
   input  logic        mem_write_i,
   input  logic [31:0] data_adr_i,
   input  logic [31:0] write_data_i,
   output logic        pass_hit_o,
   output logic        fail_hit_o
);

   logic sig_match;

   assign sig_match  = (data_adr_i == PASS_ADDR) && (write_data_i == PASS_DATA);
   // A wrong value written to the signature address is a failure, not a tolerated store.
   assign pass_hit_o = mem_write_i && sig_match;
   assign fail_hit_o = mem_write_i && !sig_match && (data_adr_i != ALLOW_ADDR);

endmodule

// File: rtl/rv32i_test_sequencer.sv
// rtl/rv32i_test_sequencer.sv - loads a program into core IMEM, runs the core, and judges its signature store
module rv32i_test_sequencer
   import rv32i_seq_pkg::*;
#(
   parameter int unsigned IMEM_WORDS     = 64,
   parameter logic [31:0] PASS_ADDR      = DEF_PASS_ADDR,
   parameter logic [31:0] PASS_DATA      = DEF_PASS_DATA,
   parameter logic [31:0] ALLOW_ADDR     = DEF_ALLOW_ADDR,
   parameter int unsigned RESET_HOLD     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   localparam int unsigned AW            = $clog2(IMEM_WORDS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          load_valid,
   output logic          load_ready,
   input  logic [31:0]   load_data,
   input  logic          load_last,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wdata,
   output logic          cpu_reset,
   input  logic          MemWrite,
   input  logic [31:0]   Data_Adr,
   input  logic [31:0]   WriteData,
   output logic          busy,
   output logic          pass,
   output logic          fail,
   output logic          timeout,
   output logic          load_trunc,
   output logic [31:0]   run_cycles
);

   localparam int unsigned HW        = $clog2(RESET_HOLD + 1);
   localparam logic [AW-1:0] LAST_PTR  = AW'(IMEM_WORDS - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);
   localparam logic [31:0]   TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

   seq_state_t state_q, state_d;

   logic [AW-1:0] ptr_q, ptr_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [31:0]   run_cycles_q, run_cycles_d;
   logic          imem_we_q, imem_we_d;
   logic [AW-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]   imem_wdata_q, imem_wdata_d;
   logic          pass_q, pass_d;
   logic          fail_q, fail_d;
   logic          timeout_q, timeout_d;
   logic          load_trunc_q, load_trunc_d;

   logic transfer;
   logic start_accept;
   logic at_last_word;
   logic pass_hit;
   logic fail_hit;

   rv32i_store_monitor #(
      .PASS_ADDR  (PASS_ADDR),
      .PASS_DATA  (PASS_DATA),
      .ALLOW_ADDR (ALLOW_ADDR)
   ) u_monitor (
      .mem_write_i  (MemWrite),
      .data_adr_i   (Data_Adr),
      .write_data_i (WriteData),
      .pass_hit_o   (pass_hit),
      .fail_hit_o   (fail_hit)
   );

   assign transfer     = load_valid && load_ready;
   assign start_accept = start && ((state_q == ST_IDLE) || is_terminal(state_q));
   assign at_last_word = (ptr_q == LAST_PTR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The monitor is consulted only in RUN, so garbage on the core bus elsewhere has no effect.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_PASS, ST_FAIL, ST_TIMEOUT: begin
            if (start) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (transfer && (load_last || at_last_word)) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (hold_q == HOLD_LAST) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (pass_hit)                        state_d = ST_PASS;
            else if (fail_hit)                   state_d = ST_FAIL;
            else if (run_cycles_q == TO_LAST)    state_d = ST_TIMEOUT;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      load_ready = (state_q == ST_LOAD);
      busy       = (state_q == ST_LOAD) || (state_q == ST_HOLD) || (state_q == ST_RUN);
      cpu_reset  = (state_q != ST_RUN);
   end

   always_comb begin
      ptr_d        = ptr_q;
      hold_d       = '0;
      run_cycles_d = run_cycles_q;
      imem_we_d    = transfer;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      pass_d       = pass_q    || ((state_q == ST_RUN) && (state_d == ST_PASS));
      fail_d       = fail_q    || ((state_q == ST_RUN) && (state_d == ST_FAIL));
      timeout_d    = timeout_q || ((state_q == ST_RUN) && (state_d == ST_TIMEOUT));
      load_trunc_d = load_trunc_q || (transfer && !load_last && at_last_word);

      if (state_q == ST_HOLD) hold_d = hold_q + HW'(1);
      if (state_q == ST_RUN)  run_cycles_d = run_cycles_q + 32'd1;

      // The pointer saturates on the last word; LOAD exits on that transfer anyway.
      if (transfer) begin
         imem_addr_d  = ptr_q;
         imem_wdata_d = load_data;
         if (!at_last_word) ptr_d = ptr_q + AW'(1);
      end

      if (start_accept) begin
         ptr_d        = '0;
         run_cycles_d = '0;
         pass_d       = 1'b0;
         fail_d       = 1'b0;
         timeout_d    = 1'b0;
         load_trunc_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q        <= '0;
         hold_q       <= '0;
         run_cycles_q <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
         timeout_q    <= 1'b0;
         load_trunc_q <= 1'b0;
      end else begin
         ptr_q        <= ptr_d;
         hold_q       <= hold_d;
         run_cycles_q <= run_cycles_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         pass_q       <= pass_d;
         fail_q       <= fail_d;
         timeout_q    <= timeout_d;
         load_trunc_q <= load_trunc_d;
      end
   end

   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign pass       = pass_q;
   assign fail       = fail_q;
   assign timeout    = timeout_q;
   assign load_trunc = load_trunc_q;
   assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_rv32i_test_sequencer.sv
// tb/tb_rv32i_test_sequencer.sv - directed self-checking bench for rv32i_test_sequencer
module tb_rv32i_test_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, load_valid, load_last, MemWrite;
   logic [31:0] load_data, Data_Adr, WriteData;
   logic        load_ready, imem_we, cpu_reset, busy, pass, fail, timeout, load_trunc;
   logic [4:0]  imem_addr;
   logic [31:0] imem_wdata, run_cycles;

   logic        s_start, s_load_valid, s_load_last;
   logic [31:0] s_load_data;
   logic        s_mem_write = 1'b0;
   logic [31:0] s_data_adr = 32'd0, s_write_data = 32'd0;
   logic        s_load_ready, s_imem_we, s_cpu_reset, s_busy, s_pass, s_fail, s_timeout, s_load_trunc;
   logic [2:0]  s_imem_addr;
   logic [31:0] s_imem_wdata, s_run_cycles;

   int          vectors = 0;
   int          miscompares = 0;
   int          wr_count = 0;
   int          w0;
   logic [31:0] mem [0:31];

   rv32i_test_sequencer #(.IMEM_WORDS(32), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .start(start),
      .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
      .MemWrite(MemWrite), .Data_Adr(Data_Adr), .WriteData(WriteData),
      .busy(busy), .pass(pass), .fail(fail), .timeout(timeout),
      .load_trunc(load_trunc), .run_cycles(run_cycles)
   );

   rv32i_test_sequencer #(.IMEM_WORDS(8), .TIMEOUT_CYCLES(16)) dut_s (
      .clk(clk), .reset(reset), .start(s_start),
      .load_valid(s_load_valid), .load_ready(s_load_ready), .load_data(s_load_data), .load_last(s_load_last),
      .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata), .cpu_reset(s_cpu_reset),
      .MemWrite(s_mem_write), .Data_Adr(s_data_adr), .WriteData(s_write_data),
      .busy(s_busy), .pass(s_pass), .fail(s_fail), .timeout(s_timeout),
      .load_trunc(s_load_trunc), .run_cycles(s_run_cycles)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (imem_we) begin
         mem[imem_addr] <= imem_wdata;
         wr_count       <= wr_count + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_main();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic load_main(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         load_valid = 1'b1;
         load_data  = base + 32'(i);
         load_last  = (i == n - 1);
         tick();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic store(input logic [31:0] adr, input logic [31:0] dat);
      MemWrite  = 1'b1;
      Data_Adr  = adr;
      WriteData = dat;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_data = '0;
      MemWrite = 1'b0; Data_Adr = '0; WriteData = '0;
      s_start = 1'b0; s_load_valid = 1'b0; s_load_last = 1'b0; s_load_data = '0;
      #2;
      chk("rst_cpu_reset", cpu_reset, 1);
      chk("rst_load_ready", load_ready, 0);
      chk("rst_imem_we", imem_we, 0);
      chk("rst_imem_addr", imem_addr, 0);
      chk("rst_imem_wdata", imem_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_flags", {pass, fail, timeout, load_trunc}, 0);
      chk("rst_run_cycles", run_cycles, 0);
      tick(); tick();
      reset = 1'b0;
      tick();

      // 1: 20-word program, tolerated store to 96, then pass signature
      start_main();
      chk("t1_load_ready", load_ready, 1);
      chk("t1_busy", busy, 1);
      w0 = wr_count;
      for (int i = 0; i < 20; i++) begin
         load_valid = 1'b1;
         load_data  = 32'hA000_0000 + 32'(i);
         load_last  = (i == 19);
         tick();
         chk("t1_imem_we", imem_we, 1);
         chk("t1_imem_addr", imem_addr, i);
      end
      load_valid = 1'b0; load_last = 1'b0;
      chk("t1_hold_ready", load_ready, 0);
      chk("t1_hold_cpu_reset0", cpu_reset, 1);
      tick();
      chk("t1_hold_cpu_reset1", cpu_reset, 1);
      chk("t1_we_dropped", imem_we, 0);
      chk("t1_write_count", wr_count - w0, 20);
      chk("t1_mem0", mem[0], 32'hA000_0000);
      chk("t1_mem19", mem[19], 32'hA000_0013);
      tick();
      chk("t1_run_cpu_reset", cpu_reset, 0);
      chk("t1_run_cycles0", run_cycles, 0);
      store(32'd96, 32'd5);
      tick();
      chk("t1_allow_ignored", {pass, fail}, 0);
      chk("t1_run_cycles1", run_cycles, 1);
      store(32'd100, 32'd25);
      tick();
      MemWrite = 1'b0;
      chk("t1_pass", pass, 1);
      chk("t1_cpu_reset_back", cpu_reset, 1);
      chk("t1_busy_end", busy, 0);
      chk("t1_run_cycles2", run_cycles, 2);

      // 2: wrong data at the signature address; garbage bus outside RUN
      MemWrite = 1'bx; Data_Adr = 32'd100; WriteData = 32'd25;
      start_main();
      chk("t2_pass_cleared", pass, 0);
      load_main(4, 32'hB000_0000);
      tick(); tick();
      chk("t2_x_ignored", {pass, fail, cpu_reset}, 0);
      store(32'd100, 32'd7);
      tick();
      MemWrite = 1'b0;
      chk("t2_fail", fail, 1);
      chk("t2_pass", pass, 0);
      chk("t2_run_cycles", run_cycles, 1);

      // 3: store to 104 before the signature
      start_main();
      chk("t3_fail_cleared", fail, 0);
      load_main(4, 32'hC000_0000);
      tick(); tick();
      tick();
      store(32'd104, 32'd25);
      tick();
      chk("t3_fail", fail, 1);
      chk("t3_run_cycles", run_cycles, 2);
      store(32'd100, 32'd25);
      tick(); tick(); tick();
      MemWrite = 1'b0;
      chk("t3_frozen", run_cycles, 2);
      chk("t3_no_pass_after", pass, 0);

      // 4: jal x0,0 loop until timeout
      start_main();
      load_main(1, 32'h0000_006F);
      tick(); tick();
      repeat (15) tick();
      chk("t4_before_to", {timeout, busy}, 2'b01);
      chk("t4_run_cycles15", run_cycles, 15);
      tick();
      chk("t4_timeout", timeout, 1);
      chk("t4_run_cycles16", run_cycles, 16);
      chk("t4_no_verdict", {pass, fail}, 0);
      chk("t4_cpu_reset", cpu_reset, 1);
      tick();
      chk("t4_frozen", run_cycles, 16);

      // 4b: verdict on the timeout cycle wins
      start_main();
      load_main(1, 32'h0000_006F);
      tick(); tick();
      repeat (15) tick();
      store(32'd100, 32'd25);
      tick();
      MemWrite = 1'b0;
      chk("t4b_pass_wins", {pass, timeout}, 2'b10);
      chk("t4b_run_cycles", run_cycles, 16);

      // 5: 8-deep IMEM filled without load_last
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      chk("t5_ready", s_load_ready, 1);
      s_load_valid = 1'b1;
      s_load_last  = 1'b0;
      for (int i = 0; i < 7; i++) begin
         s_load_data = 32'hD000_0000 + 32'(i);
         tick();
      end
      chk("t5_ready_7", s_load_ready, 1);
      chk("t5_trunc_7", s_load_trunc, 0);
      s_load_data = 32'hD000_0007;
      tick();
      chk("t5_trunc", s_load_trunc, 1);
      chk("t5_ready_off", s_load_ready, 0);
      chk("t5_busy_hold", {s_busy, s_cpu_reset}, 2'b11);
      chk("t5_last_addr", s_imem_addr, 7);
      chk("t5_last_data", s_imem_wdata, 32'hD000_0007);
      tick();
      chk("t5_no_more_writes", s_imem_we, 0);
      chk("t5_ready_stays_off", s_load_ready, 0);
      s_load_valid = 1'b0;

      // 6: async reset mid-RUN, then a clean rerun
      start_main();
      load_main(4, 32'hE000_0000);
      tick(); tick();
      tick(); tick();
      chk("t6_in_run", {busy, cpu_reset}, 2'b10);
      #2 reset = 1'b1;
      #1;
      chk("t6_flags", {pass, fail, timeout, load_trunc}, 0);
      chk("t6_cpu_reset", cpu_reset, 1);
      chk("t6_busy", busy, 0);
      chk("t6_run_cycles", run_cycles, 0);
      chk("t6_s_trunc", s_load_trunc, 0);
      tick();
      reset = 1'b0;
      tick();
      start_main();
      chk("t6_reload_ready", load_ready, 1);
      load_main(4, 32'hF000_0000);
      tick(); tick();
      store(32'd100, 32'd25);
      tick();
      MemWrite = 1'b0;
      chk("t6_pass", pass, 1);
      chk("t6_run_cycles", run_cycles, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
